// File: rtl/sha3_pkg.sv
// sha3_pkg: shared SHA3 rate, pad bytes and packer state encoding
package sha3_pkg;
  localparam int SHA3_RATE_BYTES_256 = 136;
  localparam logic [7:0] SHA3_PAD_FIRST = 8'h06;
  localparam logic [7:0] SHA3_PAD_LAST = 8'h80;
  typedef enum logic {S_FILL, S_EMIT} state_t;
endpackage

// File: rtl/sha3_pad_insert.sv
// sha3_pad_insert: ORs the SHA3 domain pad into a block at byte n and at the final rate byte
module sha3_pad_insert
  import sha3_pkg::*;
#(
  parameter int RATE_BYTES = SHA3_RATE_BYTES_256,
  parameter int NW = $clog2(RATE_BYTES + 1)
) (
  input  logic [RATE_BYTES*8-1:0] blk,
  input  logic [NW-1:0]           n,
  input  logic                    en,
  output logic [RATE_BYTES*8-1:0] padded
);
  localparam int W = RATE_BYTES * 8;
  logic [W-1:0] pad_first, pad_last;
  always_comb begin
    pad_first = W'(SHA3_PAD_FIRST) << {n, 3'b000};
    pad_last = W'(SHA3_PAD_LAST) << (W - 8);
    padded = en ? (blk | pad_first | pad_last) : blk;
  end
endmodule

// File: rtl/sha3_axis_block_packer.sv
// sha3_axis_block_packer: packs 16-bit AXIS beats into padded SHA3 rate blocks; SHA3_PACK_TKEEP_EN enables partial last beats
module sha3_axis_block_packer
  import sha3_pkg::*;
#(
  parameter int RATE_BYTES = SHA3_RATE_BYTES_256
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    TVALID,
  output logic                    TREADY,
  input  logic [15:0]             TDATA,
  input  logic [1:0]              TKEEP,
  input  logic                    TLAST,
  input  logic [1:0]              TSTRB,
  input  logic [7:0]              TID,
  input  logic                    TDEST,
  input  logic                    TUSER,
  output logic [RATE_BYTES*8-1:0] block_data,
  output logic                    block_valid,
  input  logic                    block_ready,
  output logic                    block_last
);
  localparam int W = RATE_BYTES * 8;
  localparam int NW = $clog2(RATE_BYTES + 1);
  localparam logic [NW-1:0] FULL = NW'(RATE_BYTES);
  state_t state, state_d;
  logic [NW-1:0] cnt, cnt_d, n;
  logic [W-1:0] blk, blk_d, merged, padded, pad_only;
  logic last, last_d, pend, pend_d, rdy, accept, pad_en;
  logic [1:0] nb;
  logic [15:0] beat;
  logic unused;
  assign unused = ^{TSTRB, TID, TDEST, TUSER, TKEEP};
  always_comb begin
`ifdef SHA3_PACK_TKEEP_EN
    nb = (!TLAST || TKEEP[1]) ? 2'd2 : {1'b0, TKEEP[0]};
`else
    nb = 2'd2;
`endif
    beat = nb == 2'd2 ? TDATA : nb == 2'd1 ? {8'h00, TDATA[7:0]} : 16'h0000;
    accept = TVALID && rdy;
    n = cnt + NW'(nb);
    merged = blk | (W'(beat) << {cnt, 3'b000});
    pad_en = TLAST && (n < FULL);
  end
  sha3_pad_insert #(.RATE_BYTES(RATE_BYTES)) u_pad (
    .blk(merged), .n(n), .en(pad_en), .padded(padded)
  );
  sha3_pad_insert #(.RATE_BYTES(RATE_BYTES)) u_pad_only (
    .blk('0), .n('0), .en(1'b1), .padded(pad_only)
  );
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    blk_d = blk;
    last_d = last;
    pend_d = pend;
    if (state == S_EMIT) begin
      if (block_ready) begin
        cnt_d = '0;
        blk_d = pend ? pad_only : '0;
        last_d = pend;
        pend_d = 1'b0;
        state_d = pend ? S_EMIT : S_FILL;
      end
    end else if (accept) begin
      cnt_d = n;
      blk_d = padded;
      state_d = (TLAST || n == FULL) ? S_EMIT : S_FILL;
      last_d = TLAST && (n < FULL);
      pend_d = TLAST && (n == FULL);
    end
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= S_FILL;
      cnt <= '0;
      blk <= '0;
      last <= 1'b0;
      pend <= 1'b0;
      rdy <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      blk <= blk_d;
      last <= last_d;
      pend <= pend_d;
      rdy <= state_d == S_FILL;
    end
  end
  assign TREADY = rdy;
  assign block_valid = state == S_EMIT;
  assign block_data = blk;
  assign block_last = last;
endmodule

// File: tb/tb_sha3_axis_block_packer.sv
// tb_sha3_axis_block_packer: scoreboard bench with a message-level SHA3 padding model
module tb_sha3_axis_block_packer;
  import sha3_pkg::*;
  localparam int R = SHA3_RATE_BYTES_256;
  localparam int W = R * 8;
  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } exp_t;
  logic ACLK = 0, ARESETn = 0, TVALID = 0, TLAST = 0, block_ready = 0;
  logic [15:0] TDATA = '0;
  logic [1:0] TKEEP = 2'b11;
  logic TREADY, block_valid, block_last;
  logic [W-1:0] block_data;
  exp_t q[$];
  exp_t me;
  int checks = 0, passed = 0, rdy_mode = 0;

  always #5 ACLK = ~ACLK;

  sha3_axis_block_packer dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .TVALID(TVALID), .TREADY(TREADY),
    .TDATA(TDATA), .TKEEP(TKEEP), .TLAST(TLAST), .TSTRB(2'b11), .TID(8'h5a),
    .TDEST(1'b0), .TUSER(1'b1), .block_data(block_data), .block_valid(block_valid),
    .block_ready(block_ready), .block_last(block_last)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_blk(input string nm, input exp_t e);
    int bad = -1;
    int bi;
    checks++;
    for (int i = R - 1; i >= 0; i--) if (block_data[8*i+:8] !== e.d[8*i+:8]) bad = i;
    bi = bad < 0 ? 0 : bad;
    if (bad < 0 && block_last === e.l) passed++;
    else $display("FAIL %s: byte %0d got %02h expected %02h, last got %b expected %b",
                  nm, bad, block_data[8*bi+:8], e.d[8*bi+:8], block_last, e.l);
  endtask

  // Reference: message padded to a whole number of rate blocks, 0x06 after the data, 0x80 at the very end
  task automatic push_msg(input byte unsigned m[$]);
    int nblk = m.size() / R + 1;
    byte unsigned p[$];
    exp_t e;
    for (int i = 0; i < nblk * R; i++) p.push_back(i < m.size() ? m[i] : 8'h00);
    p[m.size()] = p[m.size()] | SHA3_PAD_FIRST;
    p[nblk*R-1] = p[nblk*R-1] | SHA3_PAD_LAST;
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < R; k++) e.d[8*k+:8] = p[b*R+k];
      e.l = (b == nblk - 1);
      q.push_back(e);
    end
  endtask

  task automatic put_beat(input logic [15:0] d, input logic l, input logic [1:0] k);
    logic acc;
    int t = 0;
    TVALID = 1; TDATA = d; TLAST = l; TKEEP = k;
    do begin
      @(negedge ACLK);
      acc = TREADY;
      @(posedge ACLK);
      #1;
      t++;
    end while (!acc && t < 3000);
    TVALID = 0;
    if (!acc) begin
      checks++;
      $display("FAIL beat_accept: TREADY got 0 expected 1 within 3000 cycles");
    end
  endtask

  task automatic send(input byte unsigned m[$]);
    int L = m.size();
    int nbt = L == 0 ? 1 : (L + 1) / 2;
    int left;
    logic [7:0] b0, b1;
    logic [1:0] k;
    for (int i = 0; i < nbt; i++) begin
      left = L - 2 * i;
      b0 = left > 0 ? m[2*i] : 8'($urandom);
      b1 = left > 1 ? m[2*i+1] : 8'($urandom);
`ifdef SHA3_PACK_TKEEP_EN
      k = i < nbt - 1 ? 2'($urandom) :
          left >= 2 ? ($urandom_range(0, 1) == 1 ? 2'b10 : 2'b11) :
          left == 1 ? 2'b01 : 2'b00;
`else
      k = 2'($urandom);
`endif
      put_beat({b1, b0}, i == nbt - 1, k);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q.size() != 0 || block_valid) && t < 5000) begin
      @(posedge ACLK);
      #1;
      t++;
    end
    checks++;
    if (q.size() == 0 && !block_valid) passed++;
    else $display("FAIL drain: %0d blocks outstanding, valid %b, expected 0 and 0", q.size(), block_valid);
  endtask

  initial forever begin
    @(posedge ACLK);
    #1;
    block_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ($urandom_range(0, 2) != 0) : 1'b0;
  end

  always @(negedge ACLK) begin
    if (ARESETn && block_valid && block_ready) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_block: got a block, expected none (last %b)", block_last);
      end else begin
        me = q.pop_front();
        chk_blk("block", me);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    byte unsigned m[$];
    byte unsigned m2[$];
    exp_t e;
    repeat (3) @(negedge ACLK);
    chk("rst_tready", 64'(TREADY), 64'(0));
    chk("rst_valid", 64'(block_valid), 64'(0));
    chk("rst_last", 64'(block_last), 64'(0));
    chk("rst_data_zero", 64'(block_data == '0), 64'(1));
    @(posedge ACLK); #1;
    ARESETn = 1;
    #1 chk("tready_before_edge", 64'(TREADY), 64'(0));
    @(posedge ACLK); #1;
    chk("tready_after_edge", 64'(TREADY), 64'(1));

    // 68 beats 0x0001..0x0044: exactly one full block, then a pad-only block
    m = {};
    for (int i = 0; i < 68; i++) begin m.push_back(8'(i + 1)); m.push_back(8'h00); end
    push_msg(m);
    send(m);
    chk("full_valid", 64'(block_valid), 64'(1));
    chk("full_tready", 64'(TREADY), 64'(0));
    chk("full_last", 64'(block_last), 64'(0));
    chk("full_b0", 64'(block_data[7:0]), 64'(8'h01));
    chk("full_b1", 64'(block_data[15:8]), 64'(8'h00));
    chk("full_b135", 64'(block_data[W-1:W-8]), 64'(8'h00));
    @(posedge ACLK); #1;
    chk("padonly_valid", 64'(block_valid), 64'(1));
    chk("padonly_last", 64'(block_last), 64'(1));
    chk("padonly_b0", 64'(block_data[7:0]), 64'(8'h06));
    chk("padonly_b135", 64'(block_data[W-1:W-8]), 64'(8'h80));
    wait_drain();

    // 3-beat message, latency and in-place pad
    m = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    push_msg(m);
    send(m);
    chk("short_valid_lat1", 64'(block_valid), 64'(1));
    chk("short_tready", 64'(TREADY), 64'(0));
    chk("short_b0_6", 64'(block_data[55:0]), 64'h06FFEEDDCCBBAA);
    chk("short_b135", 64'(block_data[W-1:W-8]), 64'(8'h80));
    chk("short_last", 64'(block_last), 64'(1));
    wait_drain();

`ifdef SHA3_PACK_TKEEP_EN
    m = {};
    for (int i = 0; i < R - 1; i++) m.push_back(8'($urandom));
    push_msg(m);
    send(m);
    chk("keep01_b134", 64'(block_data[W-9:W-16]), 64'(m[R-2]));
    chk("keep01_b135", 64'(block_data[W-1:W-8]), 64'(8'h86));
    chk("keep01_last", 64'(block_last), 64'(1));
    wait_drain();
    m = {};
    push_msg(m);
    send(m);
    e.d = '0;
    e.d[7:0] = 8'h06;
    e.d[W-1:W-8] = 8'h80;
    e.l = 1'b1;
    chk_blk("empty_msg", e);
    wait_drain();
`endif

    // block_ready held low: output frozen and pending beat not consumed
    rdy_mode = 2;
    repeat (2) begin @(posedge ACLK); #1; end
    m = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    push_msg(m);
    send(m);
    m2 = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    push_msg(m2);
    TVALID = 1; TDATA = {m2[1], m2[0]}; TLAST = 0; TKEEP = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      chk("hold_valid", 64'(block_valid), 64'(1));
      chk("hold_tready", 64'(TREADY), 64'(0));
      chk_blk("hold_data", q[0]);
    end
    rdy_mode = 0;
    send(m2);
    wait_drain();

    // reset mid-message discards the partial block
    for (int i = 0; i < 20; i++) put_beat(16'($urandom), 1'b0, 2'b11);
    ARESETn = 0;
    #1;
    chk("midrst_data_zero", 64'(block_data == '0), 64'(1));
    chk("midrst_tready", 64'(TREADY), 64'(0));
    chk("midrst_valid", 64'(block_valid), 64'(0));
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1;
    m = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    push_msg(m);
    send(m);
    wait_drain();

    // randomized messages with random back-pressure
    rdy_mode = 1;
    for (int j = 0; j < 40; j++) begin
      int L;
`ifdef SHA3_PACK_TKEEP_EN
      L = $urandom_range(0, 300);
`else
      L = 2 * $urandom_range(1, 150);
`endif
      m = {};
      for (int i = 0; i < L; i++) m.push_back(8'($urandom));
      push_msg(m);
      send(m);
      repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
    end
    wait_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
